mips32_prog_loader: RTL and testbench
=====================================

// Module: mips32_prog_loader
// PURPOSE
//  Hardware host-side loader for the pipeline_processor. It streams a program image into
//  instruction memory and holds the core while loading. It then releases the core and waits
//  for HALTED. After halt it reads back the register file and streams it out as a status
//  header plus NREG words. It sits between an external word-stream host and the core's
//  Mem write port, register read port and hold/start controls.
// PARAMETERS
//  ADDR_W       10    instruction memory word-address width
//  MAX_WORDS    1024  max program words accepted (<= 2**ADDR_W)
//  NREG         32    registers dumped, R0..R(NREG-1)
//  RUN_TIMEOUT  4096  RUN cycles allowed before forced dump
// PORTS
//  clk1        in   1       single clock, all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  in_valid    in   1       program word valid
//  in_ready    out  1       loader accepts word (handshake = in_valid & in_ready)
//  in_data     in   32      program word
//  in_last     in   1       marks final program word
//  mem_we      out  1       instruction memory write strobe
//  mem_addr    out  ADDR_W  memory word address
//  mem_wdata   out  32      memory write data
//  cpu_hold    out  1       1 = core held halted
//  cpu_start   out  1       1-cycle pulse: core clears PC, HALTED and TAKEN_BRANCH
//  cpu_halted  in   1       core HALTED flag
//  reg_raddr   out  5       register read index (combinational read)
//  reg_rdata   in   32      register read data, valid in the same cycle
//  out_valid   out  1       dump word valid
//  out_ready   in   1       sink accepts dump word
//  out_data    out  32      dump word
//  out_last    out  1       marks final dump word
//  busy        out  1       state not IDLE/DONE/ERR
//  done        out  1       dump complete
//  error       out  1       load overflow; sticky until rst
// BEHAVIOUR
//  Reset: state=IDLE, cpu_hold=1, all other outputs 0, counters cleared.
//  Outputs are registered. A memory write appears on the cycle after its input handshake.
//  IDLE/LOAD: in_ready=1. Each handshake writes in_data to mem_addr=wcount, then wcount++.
//   Entry to LOAD happens on the first handshake in IDLE; that word goes to address 0.
//   Handshake with in_last=1 goes to START, with no further words accepted.
//   Handshake at wcount==MAX_WORDS-1 with in_last=0 goes to ERR: error=1, in_ready=0,
//   cpu_hold=1, and only rst exits.
//  START: exactly one cycle. cpu_start=1, cpu_hold goes 0, run counter cleared. Next state RUN.
//  RUN: run counter increments each cycle with cpu_halted=0.
//   If cpu_halted=1, go to DUMP. If counter reaches RUN_TIMEOUT, set tmo=1 and go to DUMP.
//   On DUMP entry cpu_hold=1 again.
//  DUMP: the first word is the header {tmo, 15'b0, runcount[15:0]}, followed by R0..R(NREG-1).
//   reg_raddr=index and out_data=reg_rdata are held stable while out_valid & !out_ready.
//   Index advances only on the out handshake. out_last=1 on R(NREG-1).
//   The handshake on the last word goes to DONE.
//  DONE: done=1, busy=0, in_ready=1. A new in handshake clears done and tmo, starts LOAD
//   at address 0, and writes that word.
//  in_ready=0 in START/RUN/DUMP/ERR. out_valid=0 outside DUMP.
//   mem_we is never asserted outside LOAD.
//  rst mid-operation (any state) gives IDLE on the next edge with cpu_hold=1.
//   Partial load and dump are discarded. Memory contents are not cleared.
//  cpu_halted already high during START is first sampled in RUN, giving runcount=0.
// TESTING
//  1 Load 2801000a,28020014,28030019,0ce77800,0ce77800,00222000,0ce77800,00832800,
//    fc000000 (last on 9th) -> mem writes addr 0..8 with that data in order.
//    The cycle after the final write: cpu_start=1 for 1 cycle, cpu_hold=0.
//  2 Model core: cpu_halted rises after 20 RUN cycles -> header 32'h00000014.
//    Then R0..R31 = reg model values; out_last only on R31; done=1 after that handshake.
//  3 Backpressure: toggle out_ready 1,0,0,1 during DUMP -> out_data and reg_raddr stable
//    while stalled; no word dropped or duplicated; 33 words total.
//  4 MAX_WORDS=4, four words without in_last -> error=1 and in_ready=0 after the 4th.
//    A 5th word is not accepted; cpu_start is never pulsed.
//  5 RUN_TIMEOUT=16, cpu_halted held 0 -> header 32'h80000010, cpu_hold=1, full dump follows.
//  6 rst after 3 load words, then a new 2-word load -> writes land at addr 0,1.
//    cpu_hold stays 1 through the reset.

Source files
------------

// File: rtl/mips32_prog_loader.sv
// Host-side loader: streams a program image into instruction memory, runs the core
// until HALTED or timeout, then streams out a status header and the register file.
module mips32_prog_loader #(
  parameter int ADDR_W      = 10,
  parameter int MAX_WORDS   = 1024,
  parameter int NREG        = 32,
  parameter int RUN_TIMEOUT = 4096
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  input  logic              cpu_halted,
  output logic [4:0]        reg_raddr,
  input  logic [31:0]       reg_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP, S_DONE, S_ERR
  } state_t;

  localparam int                RC_W    = $clog2(RUN_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] WMAX    = ADDR_W'(MAX_WORDS - 1);
  localparam logic [RC_W-1:0]   RC_LAST = RC_W'(RUN_TIMEOUT - 1);
  localparam logic [4:0]        RLAST   = 5'(NREG - 1);

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_wcount, w_wcount_next, w_waddr;
  logic [RC_W-1:0]     r_runcount, w_runcount_next;
  logic                r_tmo, w_tmo_next;
  logic                r_hdr, w_hdr_next;
  logic                r_in_ready, w_in_ready_next;
  logic                r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
  logic [31:0]         r_mem_wdata, w_mem_wdata_next;
  logic                r_cpu_hold, w_cpu_hold_next;
  logic                r_cpu_start, w_cpu_start_next;
  logic [4:0]          r_reg_raddr, w_reg_raddr_next;
  logic                r_out_valid, w_out_valid_next;
  logic [31:0]         r_out_data, w_out_data_next;
  logic                r_out_last, w_out_last_next;
  logic                r_busy, w_busy_next;
  logic                r_done, w_done_next;
  logic                r_error, w_error_next;

  logic w_accept, w_in_hs, w_out_hs, w_run_tmo, w_next_accept;

  assign w_accept  = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DONE);
  assign w_in_hs   = in_valid & r_in_ready & w_accept;
  // A fresh load (from IDLE or DONE) always restarts at address 0.
  assign w_waddr   = (r_state == S_LOAD) ? r_wcount : '0;
  assign w_out_hs  = r_out_valid & out_ready;
  assign w_run_tmo = (r_state == S_RUN) & ~cpu_halted & (r_runcount == RC_LAST);

  always_ff @(posedge clk1) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_LOAD, S_DONE: begin
        if (w_in_hs) begin
          if (in_last)               w_state_next = S_START;
          else if (w_waddr == WMAX)  w_state_next = S_ERR;
          else                       w_state_next = S_LOAD;
        end
      end
      S_START: w_state_next = S_RUN;
      S_RUN:   if (cpu_halted || w_run_tmo) w_state_next = S_DUMP;
      S_DUMP:  if (w_out_hs && r_out_last) w_state_next = S_DONE;
      S_ERR:   w_state_next = S_ERR;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_next_accept = (w_state_next == S_IDLE) || (w_state_next == S_LOAD) ||
                         (w_state_next == S_DONE);

  always_comb begin
    w_mem_we_next    = w_in_hs;
    w_mem_addr_next  = w_in_hs ? w_waddr : r_mem_addr;
    w_mem_wdata_next = w_in_hs ? in_data : r_mem_wdata;
    w_wcount_next    = w_in_hs ? (w_waddr + ADDR_W'(1)) : r_wcount;
    w_in_ready_next  = w_next_accept;
    w_cpu_start_next = (r_state == S_START);
    w_cpu_hold_next  = (w_state_next != S_RUN);
    w_busy_next      = !(w_next_accept && (w_state_next != S_LOAD)) && (w_state_next != S_ERR);
    w_done_next      = (w_state_next == S_DONE);
    w_error_next     = (w_state_next == S_ERR);

    w_runcount_next = r_runcount;
    if (r_state == S_START)                  w_runcount_next = '0;
    else if (r_state == S_RUN && !cpu_halted) w_runcount_next = r_runcount + RC_W'(1);

    w_tmo_next = r_tmo;
    if (w_in_hs && r_state != S_LOAD) w_tmo_next = 1'b0;
    else if (w_run_tmo)               w_tmo_next = 1'b1;

    w_out_valid_next = r_out_valid;
    w_out_data_next  = r_out_data;
    w_out_last_next  = r_out_last;
    w_reg_raddr_next = r_reg_raddr;
    w_hdr_next       = r_hdr;
    if (r_state == S_RUN && w_state_next == S_DUMP) begin
      w_out_valid_next = 1'b1;
      w_out_data_next  = {w_tmo_next, 15'b0, 16'(w_runcount_next)};
      w_out_last_next  = 1'b0;
      w_reg_raddr_next = '0;
      w_hdr_next       = 1'b1;
    end else if (r_state == S_DUMP) begin
      if (w_out_hs) begin
        if (r_out_last) begin
          w_out_valid_next = 1'b0;
          w_out_last_next  = 1'b0;
          w_reg_raddr_next = '0;
        end else if (r_hdr) begin
          // R0 is already addressed while the header is shown, so no bubble here.
          w_out_data_next = reg_rdata;
          w_out_last_next = (r_reg_raddr == RLAST);
          w_hdr_next      = 1'b0;
        end else begin
          // One idle cycle keeps reg_raddr equal to the index of the word on out_data.
          w_reg_raddr_next = r_reg_raddr + 5'd1;
          w_out_valid_next = 1'b0;
        end
      end else if (!r_out_valid) begin
        w_out_data_next  = reg_rdata;
        w_out_valid_next = 1'b1;
        w_out_last_next  = (r_reg_raddr == RLAST);
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_wcount    <= '0;
      r_runcount  <= '0;
      r_tmo       <= 1'b0;
      r_hdr       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b1;
      r_cpu_start <= 1'b0;
      r_reg_raddr <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_wcount    <= w_wcount_next;
      r_runcount  <= w_runcount_next;
      r_tmo       <= w_tmo_next;
      r_hdr       <= w_hdr_next;
      r_in_ready  <= w_in_ready_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_cpu_hold  <= w_cpu_hold_next;
      r_cpu_start <= w_cpu_start_next;
      r_reg_raddr <= w_reg_raddr_next;
      r_out_valid <= w_out_valid_next;
      r_out_data  <= w_out_data_next;
      r_out_last  <= w_out_last_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_error     <= w_error_next;
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign cpu_start = r_cpu_start;
  assign reg_raddr = r_reg_raddr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: instance A uses default sizes, instance B a
// 4-word / 16-cycle configuration; the idle instance is held in reset.
module tb_mips32_prog_loader;
  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst_a, rst_b, sel;
  logic        in_valid, in_last, cpu_halted, out_ready;
  logic [31:0] in_data;

  logic        a_in_ready, a_mem_we, a_cpu_hold, a_cpu_start, a_out_valid, a_out_last;
  logic        a_busy, a_done, a_error;
  logic [9:0]  a_mem_addr;
  logic [31:0] a_mem_wdata, a_out_data, a_reg_rdata;
  logic [4:0]  a_reg_raddr;
  logic        b_in_ready, b_mem_we, b_cpu_hold, b_cpu_start, b_out_valid, b_out_last;
  logic        b_busy, b_done, b_error;
  logic [9:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_out_data, b_reg_rdata;
  logic [4:0]  b_reg_raddr;

  function automatic logic [31:0] reg_val(input logic [4:0] j);
    return 32'hC0DE_0000 + {19'b0, j, 8'h00} + {27'b0, j};
  endfunction

  assign a_reg_rdata = reg_val(a_reg_raddr);
  assign b_reg_rdata = reg_val(b_reg_raddr);

  mips32_prog_loader #(.ADDR_W(10), .MAX_WORDS(1024), .NREG(32), .RUN_TIMEOUT(4096)) u_a (
    .clk1(clk1), .rst(rst_a), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_last(in_last), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .cpu_hold(a_cpu_hold), .cpu_start(a_cpu_start), .cpu_halted(cpu_halted),
    .reg_raddr(a_reg_raddr), .reg_rdata(a_reg_rdata), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy),
    .done(a_done), .error(a_error));

  mips32_prog_loader #(.ADDR_W(10), .MAX_WORDS(4), .NREG(32), .RUN_TIMEOUT(16)) u_b (
    .clk1(clk1), .rst(rst_b), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_last(in_last), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .cpu_hold(b_cpu_hold), .cpu_start(b_cpu_start), .cpu_halted(cpu_halted),
    .reg_raddr(b_reg_raddr), .reg_rdata(b_reg_rdata), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy),
    .done(b_done), .error(b_error));

  logic        o_in_ready, o_mem_we, o_cpu_hold, o_cpu_start, o_out_valid, o_out_last;
  logic        o_busy, o_done, o_error;
  logic [9:0]  o_mem_addr;
  logic [31:0] o_mem_wdata, o_out_data;
  logic [4:0]  o_reg_raddr;
  assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign o_mem_we    = sel ? b_mem_we    : a_mem_we;
  assign o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign o_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign o_cpu_hold  = sel ? b_cpu_hold  : a_cpu_hold;
  assign o_cpu_start = sel ? b_cpu_start : a_cpu_start;
  assign o_reg_raddr = sel ? b_reg_raddr : a_reg_raddr;
  assign o_out_valid = sel ? b_out_valid : a_out_valid;
  assign o_out_data  = sel ? b_out_data  : a_out_data;
  assign o_out_last  = sel ? b_out_last  : a_out_last;
  assign o_busy      = sel ? b_busy      : a_busy;
  assign o_done      = sel ? b_done      : a_done;
  assign o_error     = sel ? b_error     : a_error;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] prog [9];

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input int exp_addr);
    int b = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!o_in_ready && b < 20) begin
      tick();
      b++;
    end
    check_b("in_ready_wait", o_in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    $display("[TB] load word addr=%0d data=%h last=%0b", exp_addr, d, last);
    check_b("mem_we", o_mem_we, 1'b1);
    check_w("mem_addr", 32'(o_mem_addr), 32'(exp_addr));
    check_w("mem_wdata", o_mem_wdata, d);
  endtask

  task automatic recv_dump(input logic [31:0] hdr, input logic stall);
    logic [31:0] exp;
    for (int k = 0; k < 33; k++) begin
      int b = 0;
      while (!o_out_valid && b < 40) begin
        tick();
        b++;
      end
      check_b("dump_valid", o_out_valid, 1'b1);
      exp = (k == 0) ? hdr : reg_val(5'(k - 1));
      check_w("dump_data", o_out_data, exp);
      check_b("dump_last", o_out_last, k == 32);
      if (stall && (k == 1 || k == 5 || k == 32)) begin
        out_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
          tick();
          check_b("stall_valid", o_out_valid, 1'b1);
          check_w("stall_data", o_out_data, exp);
          check_w("stall_raddr", 32'(o_reg_raddr), 32'(k - 1));
        end
        out_ready = 1'b1;
      end
      $display("[TB] dump word %0d data=%h last=%0b", k, o_out_data, o_out_last);
      tick();
    end
    check_b("done_after_dump", o_done, 1'b1);
    check_b("busy_after_dump", o_busy, 1'b0);
    check_b("valid_after_dump", o_out_valid, 1'b0);
    check_b("in_ready_done", o_in_ready, 1'b1);
    check_b("hold_done", o_cpu_hold, 1'b1);
  endtask

  initial begin
    int b;
    prog[0] = 32'h2801000a; prog[1] = 32'h28020014; prog[2] = 32'h28030019;
    prog[3] = 32'h0ce77800; prog[4] = 32'h0ce77800; prog[5] = 32'h00222000;
    prog[6] = 32'h0ce77800; prog[7] = 32'h00832800; prog[8] = 32'hfc000000;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; cpu_halted = 1'b0; out_ready = 1'b1;
    rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
    tick(); tick();

    // reset state
    check_b("rst_hold", o_cpu_hold, 1'b1);
    check_b("rst_in_ready", o_in_ready, 1'b0);
    check_b("rst_mem_we", o_mem_we, 1'b0);
    check_b("rst_out_valid", o_out_valid, 1'b0);
    check_b("rst_busy", o_busy, 1'b0);
    check_b("rst_done", o_done, 1'b0);
    check_b("rst_error", o_error, 1'b0);
    check_b("rst_start", o_cpu_start, 1'b0);
    rst_a = 1'b0;

    // program load, start pulse, 20-cycle run, unstalled dump
    for (int i = 0; i < 9; i++) begin
      send_word(prog[i], i == 8, i);
      check_b("hold_load", o_cpu_hold, 1'b1);
    end
    check_b("in_ready_after_last", o_in_ready, 1'b0);
    check_b("busy_load", o_busy, 1'b1);
    tick();
    check_b("start_pulse", o_cpu_start, 1'b1);
    check_b("hold_released", o_cpu_hold, 1'b0);
    tick();
    check_b("start_one_cycle", o_cpu_start, 1'b0);
    check_b("hold_run", o_cpu_hold, 1'b0);
    repeat (19) @(posedge clk1);
    #1 cpu_halted = 1'b1;
    tick();
    check_b("hold_dump", o_cpu_hold, 1'b1);
    recv_dump(32'h00000014, 1'b0);

    // reload from DONE with halted already high, dump under backpressure
    send_word(32'h11111111, 1'b0, 0);
    check_b("done_cleared", o_done, 1'b0);
    send_word(32'h22222222, 1'b1, 1);
    recv_dump(32'h00000000, 1'b1);

    // reset in the middle of a load
    cpu_halted = 1'b0;
    send_word(32'hAAAA0000, 1'b0, 0);
    send_word(32'hAAAA0001, 1'b0, 1);
    send_word(32'hAAAA0002, 1'b0, 2);
    rst_a = 1'b1;
    tick();
    check_b("midrst_hold", o_cpu_hold, 1'b1);
    check_b("midrst_in_ready", o_in_ready, 1'b0);
    check_b("midrst_busy", o_busy, 1'b0);
    check_b("midrst_mem_we", o_mem_we, 1'b0);
    rst_a = 1'b0;
    send_word(32'hBBBB0000, 1'b0, 0);
    check_b("hold_after_rst", o_cpu_hold, 1'b1);
    send_word(32'hBBBB0001, 1'b1, 1);
    check_b("hold_before_start", o_cpu_hold, 1'b1);

    // instance B: overflow at MAX_WORDS=4
    rst_a = 1'b1; sel = 1'b1; rst_b = 1'b0;
    for (int i = 0; i < 4; i++) send_word(32'hE0000000 + 32'(i), 1'b0, i);
    check_b("ovf_error", o_error, 1'b1);
    check_b("ovf_in_ready", o_in_ready, 1'b0);
    check_b("ovf_hold", o_cpu_hold, 1'b1);
    in_valid = 1'b1; in_data = 32'hE0000004;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_b("ovf_no_write", o_mem_we, 1'b0);
      check_b("ovf_no_start", o_cpu_start, 1'b0);
      check_b("ovf_sticky", o_error, 1'b1);
    end
    $display("[TB] 5th word refused, error=%0b", o_error);
    in_valid = 1'b0;

    // instance B: timeout at RUN_TIMEOUT=16
    rst_b = 1'b1;
    tick();
    check_b("err_cleared", o_error, 1'b0);
    rst_b = 1'b0;
    send_word(32'h33333333, 1'b0, 0);
    send_word(32'h44444444, 1'b1, 1);
    b = 0;
    while (!o_out_valid && b < 60) begin
      tick();
      b++;
    end
    check_b("tmo_dump_hold", o_cpu_hold, 1'b1);
    recv_dump(32'h80000010, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
